// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the serial FIR control sequencer.
// Optional build macro: FIR_SEQ_DROP_CNT_EN (adds the busy drop counter).
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        LOAD,
        VALID
    } seq_state_e;

    localparam int unsigned DEFAULT_LENGTH = 100;
    localparam int unsigned DROP_CNT_W     = 8;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter for the MAC walk; clear has priority over enable.
module fir_tap_counter
    import fir_seq_pkg::*;
#(
    parameter int unsigned LENGTH    = DEFAULT_LENGTH,
    parameter int unsigned CNT_WIDTH = $clog2(LENGTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_WIDTH'(LENGTH - 1));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for the serial FIR MAC datapath (IDLE/MAC/LOAD/VALID).
// Optional build macro: FIR_SEQ_DROP_CNT_EN adds the drop_count port and counter.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned LENGTH    = DEFAULT_LENGTH,
    parameter int unsigned CNT_WIDTH = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    output logic                  shift_enb,
    output logic                  acc_clear,
    output logic                  count_enb,
    output logic [CNT_WIDTH-1:0]  tap_addr,
    output logic                  register_enb,
    output logic                  output_valid
`ifdef FIR_SEQ_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    seq_state_e state_q, state_d;
    logic       ready_q;
    logic       valid_q;
    logic       accept;
    logic       tap_clear;
    logic       tap_last;

    assign input_ready = ready_q && ((state_q == IDLE) || (state_q == VALID));
    assign accept      = input_valid && input_ready;

    always_comb begin
        state_d      = state_q;
        shift_enb    = 1'b0;
        acc_clear    = 1'b0;
        count_enb    = 1'b0;
        register_enb = 1'b0;
        tap_clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_enb = 1'b1;
                    acc_clear = 1'b1;
                    tap_clear = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                count_enb = 1'b1;
                if (tap_last) begin
                    tap_clear = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                register_enb = 1'b1;
                state_d      = VALID;
            end
            VALID: begin
                // Accepting here chains the next pass without an IDLE bubble.
                if (accept) begin
                    shift_enb = 1'b1;
                    acc_clear = 1'b1;
                    tap_clear = 1'b1;
                    state_d   = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            valid_q <= (state_d == VALID);
        end
    end

    assign output_valid = valid_q;

    fir_tap_counter #(
        .LENGTH    (LENGTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tap_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (tap_clear),
        .enable (count_enb),
        .count  (tap_addr),
        .last   (tap_last)
    );

`ifdef FIR_SEQ_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Samples offered before ready_q first sets are not counted as drops.
    always_comb begin
        drop_d = drop_q;
        if (input_valid && !input_ready && ready_q && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer at LENGTH=100 and LENGTH=2.
// Checks drop_count as well when built with FIR_SEQ_DROP_CNT_EN.
module tb_fir_mac_sequencer;

    localparam int L_BIG   = 100;
    localparam int L_SMALL = 2;
`ifdef FIR_SEQ_DROP_CNT_EN
    localparam bit HAS_DROP = 1'b1;
`else
    localparam bit HAS_DROP = 1'b0;
`endif

    typedef struct packed {
        logic       rdy;
        logic       sh;
        logic       ac;
        logic       ce;
        logic [9:0] tap;
        logic       re;
        logic       ov;
        logic [7:0] dc;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic iv_b, iv_s;

    logic       rdy_b, sh_b, ac_b, ce_b, re_b, ov_b;
    logic [6:0] tap_b;
    logic [7:0] dc_b;
    logic       rdy_s, sh_s, ac_s, ce_s, re_s, ov_s;
    logic [0:0] tap_s;
    logic [7:0] dc_s;

    fir_mac_sequencer #(.LENGTH(L_BIG), .CNT_WIDTH(7)) u_big (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (iv_b),
        .input_ready  (rdy_b),
        .shift_enb    (sh_b),
        .acc_clear    (ac_b),
        .count_enb    (ce_b),
        .tap_addr     (tap_b),
        .register_enb (re_b),
        .output_valid (ov_b)
`ifdef FIR_SEQ_DROP_CNT_EN
        ,
        .drop_count   (dc_b)
`endif
    );

    fir_mac_sequencer #(.LENGTH(L_SMALL), .CNT_WIDTH(1)) u_small (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (iv_s),
        .input_ready  (rdy_s),
        .shift_enb    (sh_s),
        .acc_clear    (ac_s),
        .count_enb    (ce_s),
        .tap_addr     (tap_s),
        .register_enb (re_s),
        .output_valid (ov_s)
`ifdef FIR_SEQ_DROP_CNT_EN
        ,
        .drop_count   (dc_s)
`endif
    );

`ifndef FIR_SEQ_DROP_CNT_EN
    assign dc_b = '0;
    assign dc_s = '0;
`endif

    // Reference model: pass timeline measured from the accept cycle.
    int len[2]   = '{L_BIG, L_SMALL};
    bit rdy_m[2] = '{1'b0, 1'b0};
    bit act_m[2] = '{1'b0, 1'b0};
    int acc_t[2] = '{0, 0};
    int drop_m[2] = '{0, 0};
    int cyc = 0;

    obs_t exp_b[$];
    obs_t exp_s[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic obs_t model(int d, bit iv, bit rstn);
        obs_t e = '0;
        int   ph;
        bit   busy;
        if (!rstn) begin
            act_m[d]  = 1'b0;
            rdy_m[d]  = 1'b0;
            drop_m[d] = 0;
            return e;
        end
        ph   = cyc - acc_t[d];
        busy = act_m[d] && (ph >= 1) && (ph <= len[d] + 1);
        e.rdy = rdy_m[d] && !busy;
        e.sh  = e.rdy && iv;
        e.ac  = e.sh;
        e.ce  = act_m[d] && (ph >= 1) && (ph <= len[d]);
        if (e.ce) e.tap = 10'(ph - 1);
        e.re  = act_m[d] && (ph == len[d] + 1);
        e.ov  = act_m[d] && (ph == len[d] + 2);
        e.dc  = 8'(drop_m[d]);
        if (iv && !e.rdy && rdy_m[d] && drop_m[d] < 255) drop_m[d]++;
        if (e.sh) begin
            act_m[d] = 1'b1;
            acc_t[d] = cyc;
        end
        rdy_m[d] = 1'b1;
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("rdy=%b sh=%b ac=%b ce=%b tap=%0d re=%b ov=%b dc=%0d",
                         o.rdy, o.sh, o.ac, o.ce, o.tap, o.re, o.ov, o.dc);
    endfunction

    function automatic void check(string nm, obs_t e, obs_t g);
        if (!HAS_DROP) begin
            e.dc = '0;
            g.dc = '0;
        end
        compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL %s t=%0t got {%s} expected {%s}", nm, $time, fmt(g), fmt(e));
        end
    endfunction

    always @(negedge clk) begin
        obs_t g;
        if (exp_b.size() > 0) begin
            g = {rdy_b, sh_b, ac_b, ce_b, 10'(tap_b), re_b, ov_b, dc_b};
            check("big", exp_b.pop_front(), g);
        end
        if (exp_s.size() > 0) begin
            g = {rdy_s, sh_s, ac_s, ce_s, 10'(tap_s), re_s, ov_s, dc_s};
            check("small", exp_s.pop_front(), g);
        end
    end

    task automatic step(bit ivb, bit ivs, bit rstn);
        @(posedge clk);
        #1;
        rst  = rstn;
        iv_b = ivb;
        iv_s = ivs;
        exp_b.push_back(model(0, ivb, rstn));
        exp_s.push_back(model(1, ivs, rstn));
        cyc++;
    endtask

    initial begin
        rst  = 1'b0;
        iv_b = 1'b0;
        iv_s = 1'b0;

        // Reset held, then release with no traffic
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1);

        // Single sample through a full pass
        step(1'b1, 1'b1, 1'b1);
        repeat (110) step(1'b0, 1'b0, 1'b1);

        // Back-to-back with input_valid held high
        repeat (320) step(1'b1, 1'b1, 1'b1);
        repeat (110) step(1'b0, 1'b0, 1'b1);

        // Busy drops during one pass, then random traffic to saturate
        step(1'b1, 1'b1, 1'b1);
        repeat (101) step(1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        repeat (400) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        repeat (110) step(1'b0, 1'b0, 1'b1);

        // Reset asserted mid-MAC, then quiet to confirm no stale result
        step(1'b1, 1'b1, 1'b1);
        repeat (49) step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (120) step(1'b0, 1'b0, 1'b1);

        // Random traffic with mixed densities
        repeat (1500) step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6), 1'b1);

        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (exp_b.size() != 0 || exp_s.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d/%0d pending required 0/0", exp_b.size(), exp_s.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control sequencer for the serial FIR multiply-accumulate datapath. It accepts one input sample per filter pass and issues the delay-line shift and accumulator clear. It then walks the tap counter across all LENGTH coefficients, loads the output register and flags a valid result. It replaces the ad-hoc control unit in the serial FIR top. It adds an explicit input_ready handshake so upstream logic can see when a sample will be accepted.

## Interface
Parameters:
- LENGTH, 100, number of filter taps; legal range 2..1024.
- CNT_WIDTH, $clog2(LENGTH), width of tap_addr.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_valid  input  1  sample present on the datapath input this cycle.
- input_ready  output  1  sequencer will accept a sample this cycle.
- shift_enb  output  1  shift the new sample into the delay line.
- acc_clear  output  1  clear the accumulator.
- count_enb  output  1  accumulate the product at tap_addr.
- tap_addr  output  CNT_WIDTH  coefficient/sample index for the current MAC.
- register_enb  output  1  load the accumulator into the output register.
- output_valid  output  1  one-cycle pulse; the output register holds a new result.
- drop_count  output  8  samples dropped while busy (present only with FIR_SEQ_DROP_CNT_EN).

## Operation
- States: IDLE, MAC, LOAD, VALID.
- Acceptance occurs on any cycle with input_valid && input_ready.
- input_ready = ready_q && (state==IDLE || state==VALID).
  - ready_q clears on reset and sets on the first clk edge after rst deasserts.
- IDLE:
  - On acceptance: shift_enb=1 and acc_clear=1 in that cycle (Mealy); next state MAC; tap_addr<=0.
  - Otherwise remain in IDLE.
- MAC:
  - count_enb=1 every cycle; tap_addr increments by 1.
  - When tap_addr==LENGTH-1: next state LOAD, tap_addr<=0.
- LOAD: register_enb=1 for one cycle; next state VALID.
- VALID:
  - output_valid=1 (registered, single cycle).
  - On acceptance in the same cycle: shift_enb/acc_clear pulse, next state MAC (back-to-back operation).
  - Otherwise next state IDLE.
- input_valid asserted while input_ready=0 is ignored; the sample is dropped and the datapath is not disturbed.
- tap_addr never exceeds LENGTH-1; no wrap occurs past LENGTH-1.
- Reset values while rst low: state=IDLE, tap_addr=0, and all outputs 0, including input_ready and drop_count.
- Reset asserted mid-MAC aborts immediately and asynchronously. No register_enb or output_valid is issued for the aborted sample.

## Timing
- Accept at cycle 0.
- count_enb high on cycles 1..LENGTH, with tap_addr=0..LENGTH-1 on those cycles.
- register_enb at cycle LENGTH+1.
- output_valid at cycle LENGTH+2.
- Maximum throughput is one sample per LENGTH+2 cycles (accept in VALID). The next accept therefore lands at cycle LENGTH+2.
- shift_enb, acc_clear, count_enb and register_enb are mutually exclusive in any cycle, except that shift_enb and acc_clear always pulse together.

## Configuration
- FIR_SEQ_DROP_CNT_EN defined:
  - drop_count port and counter exist.
  - The counter increments on each cycle with input_valid && !input_ready && ready_q.
  - It saturates at 255 and clears only on reset.
- Undefined: drop_count port and counter are absent; all other behaviour is identical.

## Structure
- Shared package fir_seq_pkg:
  - state enum (IDLE, MAC, LOAD, VALID);
  - default LENGTH constant;
  - drop-counter width constant (8).
- One sub-module, fir_tap_counter.
  - Ports: clk, rst, clear, enable; output count; output last (count==LENGTH-1).
  - The FSM uses last for the MAC→LOAD transition.

## Test plan
- Reset release:
  - With rst low, all outputs are 0.
  - First edge after release: input_ready=1.
  - Then input_valid held 0 → state stays IDLE; no enables pulse.
- Single sample, LENGTH=100, input_valid pulsed at cycle 0:
  - shift_enb/acc_clear at 0;
  - count_enb on cycles 1..100 with tap_addr 0..99;
  - register_enb at 101;
  - output_valid at 102 for exactly one cycle.
- Back-to-back, input_valid held high:
  - accepts at cycles 0, 102, 204;
  - output_valid at 102, 204, 306.
- Busy drop, FIR_SEQ_DROP_CNT_EN defined:
  - input_valid held high for cycles 1..101 during a pass → no extra shift_enb;
  - drop_count=101;
  - 300 further busy-cycle pulses → drop_count=255.
- Reset mid-operation:
  - rst low at cycle 50 of a MAC pass → outputs 0 immediately;
  - after release, no register_enb/output_valid appears until a new sample is accepted.
- Small LENGTH=2:
  - count_enb only on cycles 1–2 (tap_addr 0,1);
  - register_enb at 3;
  - output_valid at 4.
